// File: rtl/spi_slave_param_if.sv
// SPI pins and RAM-side rx/tx handshake of spi_slave_param.
// Signal prefixes are given from the slave's point of view.
interface spi_slave_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic              i_ss_n;
    logic              i_mosi;
    logic              o_miso;
    logic [DATA_W+1:0] o_rx_data;
    logic              o_rx_valid;
    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_valid;
    logic              o_busy;
    logic              o_frame_err;

    modport slave (
        input  i_ss_n, i_mosi, i_tx_data, i_tx_valid,
        output o_miso, o_rx_data, o_rx_valid, o_busy, o_frame_err
    );

    modport master (
        output i_ss_n, i_mosi, i_tx_data, i_tx_valid,
        input  o_miso, o_rx_data, o_rx_valid, o_busy, o_frame_err
    );
endinterface

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM: deserialises {dir, cmd, payload} frames and
// serialises RAM read data onto MISO. Define SPI_PARITY_EN to add an odd-parity bit per frame.
module spi_slave_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    spi_slave_param_if.slave io_spi
);
`ifdef SPI_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned RX_W  = DATA_W + 2 + PAR_W;
    localparam int unsigned TX_W  = DATA_W + PAR_W;
    localparam int unsigned CNT_W = $clog2(RX_W + 1);
    localparam int unsigned TMR_W = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StChkCmd, StWrite, StReadAdd, StReadData, StWaitTx, StTx, StDone
    } state_e;

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
    logic [RX_W-1:0]   r_rx_sr, w_rx_sr_nxt;
    logic [TX_W-1:0]   r_tx_sr, w_tx_sr_nxt;
    logic [DATA_W+1:0] r_rx_data, w_rx_data_nxt;
    logic              r_rx_valid, w_rx_valid_nxt;
    logic              r_frame_err, w_frame_err_nxt;
    logic              r_miso, w_miso_nxt;
    logic              r_rd_addr_held, w_rd_addr_held_nxt;
    logic              w_rx_par_ok;
    logic [TX_W-1:0]   w_tx_load;

`ifdef SPI_PARITY_EN
    assign w_rx_par_ok = ^r_rx_sr;
    assign w_tx_load   = {io_spi.i_tx_data, ~^io_spi.i_tx_data};
`else
    assign w_rx_par_ok = 1'b1;
    assign w_tx_load   = io_spi.i_tx_data;
`endif

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_tmr_nxt          = r_tmr;
        w_rx_sr_nxt        = r_rx_sr;
        w_tx_sr_nxt        = r_tx_sr;
        w_rx_data_nxt      = r_rx_data;
        w_rx_valid_nxt     = 1'b0;
        w_frame_err_nxt    = 1'b0;
        w_miso_nxt         = 1'b0;
        w_rd_addr_held_nxt = r_rd_addr_held;

        if (r_state != StIdle && io_spi.i_ss_n) begin
            w_state_nxt     = StIdle;
            w_cnt_nxt       = '0;
            w_tmr_nxt       = '0;
            w_frame_err_nxt = (((r_state == StWrite) || (r_state == StReadAdd) ||
                                (r_state == StReadData)) && (r_cnt != '0)) ||
                              (r_state == StWaitTx) || (r_state == StTx);
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!io_spi.i_ss_n) begin
                        w_state_nxt = StChkCmd;
                        w_cnt_nxt   = '0;
                    end
                end
                StChkCmd: begin
                    w_cnt_nxt = '0;
                    if (!io_spi.i_mosi) begin
                        w_state_nxt = StWrite;
                    end else if (r_rd_addr_held) begin
                        w_state_nxt = StReadData;
                    end else begin
                        w_state_nxt = StReadAdd;
                    end
                end
                StWrite, StReadAdd, StReadData: begin
                    if (r_cnt != CNT_W'(RX_W)) begin
                        w_rx_sr_nxt = {r_rx_sr[RX_W-2:0], io_spi.i_mosi};
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = StDone;
                        // A parity failure ends the frame without touching the address state.
                        if (w_rx_par_ok) begin
                            w_rx_data_nxt  = r_rx_sr[RX_W-1 -: DATA_W+2];
                            w_rx_valid_nxt = 1'b1;
                            if (r_state == StReadAdd) begin
                                w_rd_addr_held_nxt = 1'b1;
                            end
                            if (r_state == StReadData) begin
                                w_state_nxt = StWaitTx;
                                w_tmr_nxt   = '0;
                            end
                        end else begin
                            w_frame_err_nxt = 1'b1;
                        end
                    end
                end
                StWaitTx: begin
                    if (io_spi.i_tx_valid) begin
                        w_miso_nxt  = w_tx_load[TX_W-1];
                        w_tx_sr_nxt = w_tx_load << 1;
                        w_cnt_nxt   = CNT_W'(1);
                        w_tmr_nxt   = '0;
                        w_state_nxt = StTx;
                    end else if (r_tmr == TMR_W'(TX_TIMEOUT - 1)) begin
                        w_frame_err_nxt = 1'b1;
                        w_tmr_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = StDone;
                    end else begin
                        w_tmr_nxt = r_tmr + TMR_W'(1);
                    end
                end
                StTx: begin
                    if (r_cnt != CNT_W'(TX_W)) begin
                        w_miso_nxt  = r_tx_sr[TX_W-1];
                        w_tx_sr_nxt = r_tx_sr << 1;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end else begin
                        w_rd_addr_held_nxt = 1'b0;
                        w_cnt_nxt          = '0;
                        w_state_nxt        = StDone;
                    end
                end
                StDone: begin
                    // Counter saturates at 3 so an overrun is flagged only once per frame.
                    if (r_cnt != CNT_W'(3)) begin
                        w_cnt_nxt       = r_cnt + CNT_W'(1);
                        w_frame_err_nxt = (r_cnt == CNT_W'(2));
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_tmr          <= '0;
            r_rx_sr        <= '0;
            r_tx_sr        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_frame_err    <= 1'b0;
            r_miso         <= 1'b0;
            r_rd_addr_held <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_tmr          <= w_tmr_nxt;
            r_rx_sr        <= w_rx_sr_nxt;
            r_tx_sr        <= w_tx_sr_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid     <= w_rx_valid_nxt;
            r_frame_err    <= w_frame_err_nxt;
            r_miso         <= w_miso_nxt;
            r_rd_addr_held <= w_rd_addr_held_nxt;
        end
    end

    assign io_spi.o_miso      = r_miso;
    assign io_spi.o_rx_data   = r_rx_data;
    assign io_spi.o_rx_valid  = r_rx_valid;
    assign io_spi.o_frame_err = r_frame_err;
    assign io_spi.o_busy      = (r_state != StIdle);
endmodule
